// File: rtl/vga_crtc.sv
// vga_crtc: CRTC timing generator; every output is a registered decode of hcnt/vcnt, one clk of latency.
// No backpressure: enable low parks the counters at origin. `VGA_CRTC_PROG_EN builds the frame-synchronous timing write port.
module vga_crtc #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        enable,
  input  logic        cfg_we,
  input  logic [2:0]  cfg_addr,
  input  logic [11:0] cfg_wdata,
  output logic        hsync,
  output logic        vsync,
  output logic        data_en,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        line_start,
  output logic        frame_start,
  output logic [8:0]  frame
);

  localparam logic [95:0] DEFAULTS = {12'(V_BP), 12'(V_SYNC), 12'(V_FP), 12'(V_ACTIVE),
                                      12'(H_BP), 12'(H_SYNC), 12'(H_FP), 12'(H_ACTIVE)};

  logic [11:0] act [8];
  logic [12:0] hcnt, vcnt;
  logic [12:0] h_sync_start, h_sync_end, h_total;
  logic [12:0] v_sync_start, v_sync_end, v_total;
  logic        h_wrap, v_wrap, eof;

  assign h_sync_start = {1'b0, act[0]} + {1'b0, act[1]};
  assign h_sync_end   = h_sync_start + {1'b0, act[2]};
  assign h_total      = h_sync_end + {1'b0, act[3]};
  assign v_sync_start = {1'b0, act[4]} + {1'b0, act[5]};
  assign v_sync_end   = v_sync_start + {1'b0, act[6]};
  assign v_total      = v_sync_end + {1'b0, act[7]};

  // cnt+1 >= total rather than cnt >= total-1, so totals of 0 and 1 wrap every cycle
  assign h_wrap = ({1'b0, hcnt} + 14'd1) >= {1'b0, h_total};
  assign v_wrap = ({1'b0, vcnt} + 14'd1) >= {1'b0, v_total};
  assign eof    = h_wrap && v_wrap;

`ifdef VGA_CRTC_PROG_EN
  logic [11:0] pend     [8];
  logic [11:0] pend_nxt [8];

  always_comb begin
    for (int i = 0; i < 8; i++) pend_nxt[i] = pend[i];
    if (cfg_we) pend_nxt[cfg_addr] = cfg_wdata;
  end

  // pend_nxt feeds the commit so a write landing on the commit cycle goes straight through
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 8; i++) begin
        pend[i] <= DEFAULTS[i*12 +: 12];
        act[i]  <= DEFAULTS[i*12 +: 12];
      end
    end else begin
      for (int i = 0; i < 8; i++) pend[i] <= pend_nxt[i];
      if (!enable || eof) begin
        for (int i = 0; i < 8; i++) act[i] <= pend_nxt[i];
      end
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{cfg_we, cfg_addr, cfg_wdata};

  always_comb begin
    for (int i = 0; i < 8; i++) act[i] = DEFAULTS[i*12 +: 12];
  end
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hcnt        <= '0;
      vcnt        <= '0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      data_en     <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      xpos        <= '0;
      ypos        <= '0;
      frame       <= '0;
    end else if (!enable) begin
      hcnt        <= '0;
      vcnt        <= '0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      data_en     <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      xpos        <= '0;
      ypos        <= '0;
    end else begin
      hsync       <= (hcnt >= h_sync_start) && (hcnt < h_sync_end);
      vsync       <= (vcnt >= v_sync_start) && (vcnt < v_sync_end);
      data_en     <= (hcnt < {1'b0, act[0]}) && (vcnt < {1'b0, act[4]});
      line_start  <= (hcnt == 13'd0);
      frame_start <= (hcnt == 13'd0) && (vcnt == 13'd0);
      xpos        <= hcnt[11:0];
      ypos        <= vcnt[11:0];
      if (h_wrap) begin
        hcnt <= '0;
        vcnt <= v_wrap ? 13'd0 : vcnt + 13'd1;
      end else begin
        hcnt <= hcnt + 13'd1;
      end
      if (eof) frame <= frame + 9'd1;
    end
  end

endmodule

// File: tb/tb_vga_crtc.sv
// Directed bench for vga_crtc on a shrunken 25x13 raster, checked every cycle against a behavioural model.
module tb_vga_crtc;
  localparam int HA = 16, HF = 2, HS = 3, HB = 4, VA = 8, VF = 1, VS = 2, VB = 2;
  localparam int DEF [8] = '{HA, HF, HS, HB, VA, VF, VS, VB};
`ifdef VGA_CRTC_PROG_EN
  localparam int L_A = 17, D_A = 8, L_B = 21, D_B = 12, L_C = 23, D_C = 14;
`else
  localparam int L_A = 25, D_A = 16, L_B = 25, D_B = 16, L_C = 25, D_C = 16;
`endif

  logic        clk = 1'b0, resetn = 1'b0, enable = 1'b0, cfg_we = 1'b0;
  logic [2:0]  cfg_addr = '0;
  logic [11:0] cfg_wdata = '0;
  logic        hsync, vsync, data_en, line_start, frame_start;
  logic [11:0] xpos, ypos;
  logic [8:0]  frame;

  int n_chk = 0, n_fail = 0;

  vga_crtc #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
             .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .hsync(hsync), .vsync(vsync), .data_en(data_en), .xpos(xpos),
    .ypos(ypos), .line_start(line_start), .frame_start(frame_start), .frame(frame));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // Model: raster position as plain integers, fields as arrays, outputs from the layout rules
  int pend [8], act [8];
  int mh, mv, mframe;
  logic e_hs, e_vs, e_de, e_ls, e_fs, e_dis;
  int e_x, e_y;

  always @(posedge clk or negedge resetn) begin : model
    int hs0, hs1, ht, vs0, vs1, vt;
    bit eof;
    if (!resetn) begin
      for (int i = 0; i < 8; i++) begin pend[i] = DEF[i]; act[i] = DEF[i]; end
      mh = 0; mv = 0; mframe = 0;
      {e_hs, e_vs, e_de, e_ls, e_fs, e_dis} = '0;
      e_x = 0; e_y = 0;
    end else begin
      hs0 = act[0] + act[1]; hs1 = hs0 + act[2]; ht = (hs1 + act[3]) % 8192;
      vs0 = act[4] + act[5]; vs1 = vs0 + act[6]; vt = (vs1 + act[7]) % 8192;
      eof = 0;
`ifdef VGA_CRTC_PROG_EN
      if (cfg_we) pend[cfg_addr] = int'(cfg_wdata);
`endif
      if (!enable) begin
        {e_hs, e_vs, e_de, e_ls, e_fs} = '0;
        e_dis = 1'b1;
        mh = 0; mv = 0;
        for (int i = 0; i < 8; i++) act[i] = pend[i];
      end else begin
        e_dis = 1'b0;
        e_hs = (mh >= hs0) && (mh < hs1);
        e_vs = (mv >= vs0) && (mv < vs1);
        e_de = (mh < act[0]) && (mv < act[4]);
        e_ls = (mh == 0);
        e_fs = (mh == 0) && (mv == 0);
        e_x = mh; e_y = mv;
        if (mh + 1 >= ht) begin
          mh = 0;
          if (mv + 1 >= vt) begin mv = 0; eof = 1; mframe = (mframe + 1) % 512; end
          else mv++;
        end else mh++;
        if (eof) for (int i = 0; i < 8; i++) act[i] = pend[i];
      end
    end
  end

  always @(negedge clk) begin
    if (resetn) begin
      chk("cycle_flags", {hsync, vsync, data_en, line_start, frame_start, frame},
          {e_hs, e_vs, e_de, e_ls, e_fs, 9'(mframe)});
      if (!e_dis) chk("cycle_pos", {xpos, ypos}, {12'(e_x), 12'(e_y)});
    end
  end

  task automatic timeout(input string name);
    n_chk++; n_fail++;
    $display("FAIL %s: wait budget expired, required event never seen", name);
  endtask

  task automatic wait_xy(input int x, input int y);
    for (int i = 0; i < 3000; i++) begin
      if (xpos == 12'(x) && ypos == 12'(y)) return;
      @(negedge clk);
    end
    timeout("wait_xy");
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [11:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Length and visible pixel count of line 0 of the next frame
  task automatic measure_line(output int len, output int de);
    int i;
    len = 0; de = 0;
    for (i = 0; i < 3000 && !frame_start; i++) @(negedge clk);
    if (!frame_start) begin timeout("frame_start"); return; end
    len = 1; de = int'(data_en);
    for (i = 0; i < 100; i++) begin
      @(negedge clk);
      if (line_start) return;
      len++; de += int'(data_en);
    end
    timeout("line_start");
  endtask

  initial begin
    int len, de, c_de, c_ls, c_fs, c_vs, c_hs0, c_hsv, c_bad, first_hx, c_on;
    #2;
    chk("reset_flags", {hsync, vsync, data_en, line_start, frame_start, frame}, 0);
    chk("reset_pos", {xpos, ypos}, 0);
    #10; resetn = 1'b1; enable = 1'b1;

    c_de = 0; c_ls = 0; c_fs = 0; c_vs = 0; c_hs0 = 0; c_hsv = 0; c_bad = 0; first_hx = -1;
    for (int i = 0; i < 650; i++) begin
      @(negedge clk);
      if (i == 0) chk("first_edge", {data_en, line_start, frame_start, xpos}, {3'b111, 12'd0});
      if (i == 1) chk("second_edge", {data_en, line_start, frame_start, xpos}, {3'b100, 12'd1});
      c_de += int'(data_en); c_ls += int'(line_start); c_fs += int'(frame_start);
      c_vs += int'(vsync); c_hsv += int'(hsync && vsync);
      if (hsync && ypos == 0) c_hs0++;
      if (hsync && first_hx < 0) first_hx = int'(xpos);
      if (data_en && xpos >= 12'(HA)) c_bad++;
    end
    chk("de_count", c_de, 256);
    chk("line_starts", c_ls, 26);
    chk("frame_starts", c_fs, 2);
    chk("frame_after_2", frame, 2);
    chk("hsync_first_x", first_hx, 18);
    chk("hsync_width_line0", c_hs0, 6);
    chk("vsync_cycles", c_vs, 100);
    chk("hsync_in_vsync", c_hsv, 12);
    chk("de_in_blank", c_bad, 0);

    wait_xy(0, 3);
    cfg_write(3'd0, 12'd8);
    wait_xy(0, 5);
    de = int'(data_en);
    repeat (24) begin @(negedge clk); de += int'(data_en); end
    chk("old_frame_de", de, 16);
    measure_line(len, de);
    chk("new_line_len", len, L_A);
    chk("new_line_de", de, D_A);

    wait_xy(L_A - 2, 12);
    cfg_write(3'd0, 12'd12);
    chk("wrap_sample_x", xpos, L_A - 1);
    measure_line(len, de);
    chk("wrap_line_len", len, L_B);
    chk("wrap_line_de", de, D_B);

    wait_xy(0, 2);
    cfg_write(3'd0, 12'd10);
    cfg_write(3'd0, 12'd14);
    measure_line(len, de);
    chk("b2b_line_len", len, L_C);
    chk("b2b_line_de", de, D_C);

    wait_xy(5, 3);
    enable = 1'b0;
    c_on = 0;
    repeat (10) begin
      @(negedge clk);
      c_on += int'(hsync | vsync | data_en | line_start | frame_start);
    end
    chk("disabled_outs", c_on, 0);
    chk("frame_hold", frame, 5);
    enable = 1'b1;
    @(negedge clk);
    chk("reenable", {frame_start, line_start, xpos}, {2'b11, 12'd0});

    wait_xy(3, 4);
    cfg_write(3'd6, 12'd5);
    cfg_write(3'd0, 12'd6);
    #2 resetn = 1'b0;
    #1;
    chk("async_reset_flags", {hsync, vsync, data_en, line_start, frame_start, frame}, 0);
    chk("async_reset_pos", {xpos, ypos}, 0);
    @(negedge clk);
    #2 resetn = 1'b1;
    c_vs = 0; c_de = 0; c_fs = 0;
    repeat (325) begin
      @(negedge clk);
      c_vs += int'(vsync); c_de += int'(data_en); c_fs += int'(frame_start);
    end
    chk("post_reset_vsync", c_vs, 50);
    chk("post_reset_de", c_de, 128);
    chk("post_reset_fs", c_fs, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
